// File: rtl/rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback queue.
// Default widths match the RV32 register file.
package rf_wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired to zero, so results aimed at it are dropped.
    function automatic logic rd_is_zero(input logic [31:0] rd);
        return rd == 32'd0;
    endfunction

endpackage

// File: rtl/wb_dual_push_fifo.sv
// In-order ring buffer with two ordered push ports and one pop port.
// Per-entry valid/rd are exported so the parent can decode pending destinations.
module wb_dual_push_fifo
    import rf_wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  ADDR_W  = ADDR_W_DEF,
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push0_en,
    input  entry_t                       push0_entry,
    input  logic                         push1_en,
    input  entry_t                       push1_entry,
    input  logic                         pop_en,
    output logic [CNT_W-1:0]             count,
    output entry_t                       head,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   slot1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        // Second push lands behind the first only when the first actually happened.
        slot1    = wr_ptr_q + PTR_W'(push0_en);
        if (pop_en) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push0_en) begin
            mem_d[wr_ptr_q]   = push0_entry;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (push1_en) begin
            mem_d[slot1]   = push1_entry;
            valid_d[slot1] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_en) + PTR_W'(push1_en);
        count_d  = count_q + CNT_W'(push0_en) + CNT_W'(push1_en) - CNT_W'(pop_en);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the payload array is deliberately not reset; the valid bits and count qualify every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i] = mem_q[i].rd;
        end
    end

    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign ent_valid = valid_q;

endmodule

// File: rtl/rf_writeback_queue.sv
// Collects ALU and load results into an in-order queue and issues one
// register-file write per cycle; exports a pending-destination mask for decode.
module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    input  logic                  alu_valid,
    input  logic [ADDR_W-1:0]     alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic [2**ADDR_W-1:0]  pending,
    output logic                  idle
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    logic [CNT_W-1:0]             count;
    entry_t                       head;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic                         push0_en, push1_en;

    // Readies ignore the same-cycle pop; the ALU yields the last slot to the load path.
    assign mem_ready = reset_n && (count < CNT_W'(DEPTH));
    assign alu_ready = reset_n && ((count < CNT_W'(DEPTH - 1)) ||
                                   ((count == CNT_W'(DEPTH - 1)) && !mem_valid));

    assign push0_en = mem_valid && mem_ready && !rd_is_zero(32'(mem_rd));
    assign push1_en = alu_valid && alu_ready && !rd_is_zero(32'(alu_rd));

    wb_dual_push_fifo #(
        .entry_t (entry_t),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push0_en    (push0_en),
        .push0_entry ('{rd: mem_rd, data: mem_data}),
        .push1_en    (push1_en),
        .push1_entry ('{rd: alu_rd, data: alu_data}),
        .pop_en      (wr_en),
        .count       (count),
        .head        (head),
        .ent_valid   (ent_valid),
        .ent_rd      (ent_rd)
    );

    assign idle    = (count == '0);
    assign wr_en   = !idle;
    assign wr_addr = wr_en ? head.rd   : '0;
    assign wr_data = wr_en ? head.data : '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending[ent_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: inputs change 1ns after each rising edge,
// outputs are checked mid-cycle and committed writes are logged on the falling edge.
module tb_rf_writeback_queue;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              mem_valid, alu_valid;
    logic [ADDR_W-1:0] mem_rd, alu_rd;
    logic [XLEN-1:0]   mem_data, alu_data;
    logic              mem_ready, alu_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [31:0]       pending;
    logic              idle;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] log_addr [$];
    logic [XLEN-1:0]   log_data [$];

    always #5 clk = ~clk;

    rf_writeback_queue #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pending   (pending),
        .idle      (idle)
    );

    // A write commits at the rising edge following a cycle with wr_en high.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr [6];
        logic [XLEN-1:0]   exp_data [6];
        exp_addr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};

        // Reset held for three cycles with both sources offering.
        reset_n   = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1111;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222;
        repeat (3) cyc();
        check("rst_wr_en",     64'(wr_en),     64'(0));
        check("rst_wr_addr",   64'(wr_addr),   64'(0));
        check("rst_wr_data",   64'(wr_data),   64'(0));
        check("rst_pending",   64'(pending),   64'(0));
        check("rst_idle",      64'(idle),      64'(1));
        check("rst_mem_ready", 64'(mem_ready), 64'(0));
        check("rst_alu_ready", 64'(alu_ready), 64'(0));
        drive_idle();
        reset_n = 1'b1;
        cyc();
        check("rst_no_writes", 64'(log_addr.size()), 64'(0));
        check("rst_idle_after", 64'(idle), 64'(1));

        // Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("single_alu_ready", 64'(alu_ready), 64'(1));
        cyc();
        drive_idle();
        #1;
        check("single_wr_en",   64'(wr_en),   64'(1));
        check("single_wr_addr", 64'(wr_addr), 64'(5));
        check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
        check("single_pending", 64'(pending), 64'h20);
        check("single_busy",    64'(idle),    64'(0));
        cyc();
        check("single_idle",    64'(idle),    64'(1));
        check("single_wr_off",  64'(wr_en),   64'(0));
        check("single_pend_clr", 64'(pending), 64'(0));

        // Dual push to the same rd: mem entry precedes ALU entry.
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        #1;
        check("dual_mem_ready", 64'(mem_ready), 64'(1));
        check("dual_alu_ready", 64'(alu_ready), 64'(1));
        cyc();
        drive_idle();
        #1;
        check("dual_first_addr", 64'(wr_addr), 64'(3));
        check("dual_first_data", 64'(wr_data), 64'h11);
        check("dual_first_pend", 64'(pending), 64'h8);
        cyc();
        check("dual_second_en",   64'(wr_en),   64'(1));
        check("dual_second_data", 64'(wr_data), 64'h22);
        check("dual_second_pend", 64'(pending), 64'h8);
        cyc();
        check("dual_idle", 64'(idle),    64'(1));
        check("dual_pend", 64'(pending), 64'(0));

        // Fill: count goes 0 -> 2 -> 3, then the ALU must yield the last slot.
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA1;
        cyc();
        mem_rd = 5'd12; mem_data = 32'hA2;
        alu_rd = 5'd13; alu_data = 32'hA3;
        #1;
        check("fill_c2_alu_ready", 64'(alu_ready), 64'(1));
        check("fill_c2_head",      64'(wr_addr),   64'(10));
        check("fill_c2_pending",   64'(pending),   64'h0C00);
        cyc();
        mem_rd = 5'd14; mem_data = 32'hA4;
        alu_rd = 5'd15; alu_data = 32'hA5;
        #1;
        check("fill_c3_mem_ready", 64'(mem_ready), 64'(1));
        check("fill_c3_alu_ready", 64'(alu_ready), 64'(0));
        check("fill_c3_pending",   64'(pending),   64'h3800);
        cyc();
        mem_valid = 1'b0;
        #1;
        check("fill_c3_alu_alone", 64'(alu_ready), 64'(1));
        cyc();
        drive_idle();
        #1;
        check("fill_c3_pend_last", 64'(pending), 64'hE000);
        repeat (3) cyc();
        check("fill_drained", 64'(idle), 64'(1));
        check("fill_log_size", 64'(log_addr.size()), 64'(9));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_order_addr%0d", i), 64'(log_addr[3+i]), 64'(exp_addr[i]));
            check($sformatf("fill_order_data%0d", i), 64'(log_data[3+i]), 64'(exp_data[i]));
        end

        // ALU write to x0 is accepted but never reaches the register file.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0;
        #1;
        check("x0_alu_ready", 64'(alu_ready), 64'(1));
        cyc();
        drive_idle();
        #1;
        check("x0_wr_en",   64'(wr_en),   64'(0));
        check("x0_pending", 64'(pending), 64'(0));
        check("x0_idle",    64'(idle),    64'(1));

        // Queue three entries, then reset mid-queue.
        mem_valid = 1'b1; mem_rd = 5'd7;  mem_data = 32'h71;
        alu_valid = 1'b1; alu_rd = 5'd8;  alu_data = 32'h81;
        cyc();
        mem_rd = 5'd9;  mem_data = 32'h91;
        alu_rd = 5'd20; alu_data = 32'h201;
        cyc();
        drive_idle();
        #1;
        check("mid_pending", 64'(pending), 64'h0010_0300);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr_en",     64'(wr_en),     64'(0));
        check("mid_rst_wr_addr",   64'(wr_addr),   64'(0));
        check("mid_rst_wr_data",   64'(wr_data),   64'(0));
        check("mid_rst_pending",   64'(pending),   64'(0));
        check("mid_rst_idle",      64'(idle),      64'(1));
        check("mid_rst_mem_ready", 64'(mem_ready), 64'(0));
        check("mid_rst_alu_ready", 64'(alu_ready), 64'(0));
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        check("mid_no_more_writes", 64'(log_addr.size()), 64'(10));
        check("mid_last_write",     64'(log_data[9]),     64'h71);
        check("mid_idle_after",     64'(idle),            64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
